// File: rtl/enc_pkg.sv
// Shared constants, scan FSM encoding and the clamped-step helper for encoder_scan_ctrl.
package enc_pkg;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  localparam int ACCEL_THRESH = 4;
  localparam int AGE_MAX      = 15;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Saturating add into [0, max_v]; a step already at a rail leaves the value unchanged.
  function automatic int clamp_add(input int cur, input int delta, input int max_v);
    int s;
    s = cur + delta;
    if (s > max_v) s = max_v;
    else if (s < 0) s = 0;
    return s;
  endfunction

endpackage

// File: rtl/enc_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting channel at or after ptr_i, wrapping.
module enc_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to ptr_i so the nearest requester wins.
  always_comb begin
    gnt_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        gnt_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/encoder_scan_ctrl.sv
// Time-multiplexed quadrature encoder scanner with clamped positions and a round-robin event port.
// Define ENC_ACCEL_EN to double the step size for steps arriving within ACCEL_THRESH ticks.
module encoder_scan_ctrl
  import enc_pkg::*;
#(
  parameter int N_ENC    = 4,
  parameter int TICK_DIV = 100000,
  parameter int VAL_W    = 6,
  parameter int MAX_VAL  = 36,
  parameter int INIT_VAL = 18,
  parameter int IDW      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_ENC-1:0]       enc_a,
  input  logic [N_ENC-1:0]       enc_b,
  output logic [N_ENC*VAL_W-1:0] value_flat,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDW-1:0]         evt_id,
  output logic                   evt_dir,
  output logic [VAL_W-1:0]       evt_value,
  output logic [N_ENC-1:0]       overflow,
  output logic                   scan_busy
);

  localparam int IW = $clog2(N_ENC);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [N_ENC-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [N_ENC-1:0] db_a_q, db_b_q, pa_q, pb_q;
  logic [N_ENC-1:0] pend_q, dir_q, ovf_q;
  logic [VAL_W-1:0] val_q [N_ENC];
`ifdef ENC_ACCEL_EN
  logic [3:0]       age_q [N_ENC];
`endif

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;
  scan_state_e      state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic             evt_valid_q, evt_dir_q, dirty_q;
  logic [IW-1:0]    evt_id_q, rr_q;
  logic [VAL_W-1:0] evt_value_q;

  logic             sa, sb, db_a_new, db_b_new, step, dir_new;
  logic [VAL_W-1:0] val_new;
  int               step_sz;
  logic             gnt, acc, same_evt;
  logic [IW-1:0]    gnt_idx;

  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = SCAN;
        idx_d   = '0;
      end
      SCAN: if (idx_q == IW'(N_ENC - 1)) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared datapath for the channel under scan; a new sample is accepted only if it matches the previous tick's raw sample.
  always_comb begin
    sa       = a_s2_q[idx_q];
    sb       = b_s2_q[idx_q];
    db_a_new = (sa == pa_q[idx_q]) ? sa : db_a_q[idx_q];
    db_b_new = (sb == pb_q[idx_q]) ? sb : db_b_q[idx_q];
    step     = (state_q == SCAN) && db_a_q[idx_q] && !db_a_new;
    dir_new  = db_b_new ? DIR_CW : DIR_CCW;
    step_sz  = 1;
`ifdef ENC_ACCEL_EN
    if (int'(age_q[idx_q]) < ACCEL_THRESH) step_sz = 2;
`endif
    val_new  = VAL_W'(clamp_add(int'(val_q[idx_q]),
                                (dir_new == DIR_CCW) ? step_sz : -step_sz, MAX_VAL));
  end

  enc_rr_arbiter #(.N(N_ENC), .IW(IW)) u_arb (
    .req_i (pend_q),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign acc      = evt_valid_q && evt_ready;
  assign same_evt = step && (idx_q == evt_id_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1_q      <= '1;
      a_s2_q      <= '1;
      b_s1_q      <= '1;
      b_s2_q      <= '1;
      db_a_q      <= '1;
      db_b_q      <= '1;
      pa_q        <= '1;
      pb_q        <= '1;
      pend_q      <= '0;
      dir_q       <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < N_ENC; i++) begin
        val_q[i] <= VAL_W'(INIT_VAL);
`ifdef ENC_ACCEL_EN
        age_q[i] <= 4'(AGE_MAX);
`endif
      end
      cnt_q       <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_dir_q   <= 1'b0;
      evt_value_q <= '0;
      rr_q        <= '0;
      dirty_q     <= 1'b0;
    end else begin
      a_s1_q  <= enc_a;
      a_s2_q  <= a_s1_q;
      b_s1_q  <= enc_b;
      b_s2_q  <= b_s1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;

      if (state_q == SCAN) begin
        pa_q[idx_q]   <= sa;
        pb_q[idx_q]   <= sb;
        db_a_q[idx_q] <= db_a_new;
        db_b_q[idx_q] <= db_b_new;
`ifdef ENC_ACCEL_EN
        if (step) age_q[idx_q] <= '0;
        else if (int'(age_q[idx_q]) < AGE_MAX) age_q[idx_q] <= age_q[idx_q] + 4'd1;
`endif
        if (step) begin
          val_q[idx_q]  <= val_new;
          dir_q[idx_q]  <= dir_new;
          pend_q[idx_q] <= 1'b1;
          if (pend_q[idx_q]) ovf_q[idx_q] <= 1'b1;
        end
      end

      // dirty_q remembers a step that landed on the presented channel, so acceptance must not drop it.
      if (acc) begin
        evt_valid_q <= 1'b0;
        rr_q        <= (evt_id_q == IW'(N_ENC - 1)) ? '0 : evt_id_q + IW'(1);
        dirty_q     <= 1'b0;
        if (!dirty_q && !same_evt) pend_q[evt_id_q] <= 1'b0;
      end else if (evt_valid_q) begin
        if (same_evt) dirty_q <= 1'b1;
      end else if (gnt) begin
        evt_valid_q <= 1'b1;
        evt_id_q    <= gnt_idx;
        evt_dir_q   <= (step && idx_q == gnt_idx) ? dir_new : dir_q[gnt_idx];
        evt_value_q <= (step && idx_q == gnt_idx) ? val_new : val_q[gnt_idx];
      end
    end
  end

  for (genvar g = 0; g < N_ENC; g++) begin : g_val
    assign value_flat[g*VAL_W +: VAL_W] = val_q[g];
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = IDW'(evt_id_q);
  assign evt_dir   = evt_dir_q;
  assign evt_value = evt_value_q;
  assign overflow  = ovf_q;
  assign scan_busy = (state_q == SCAN);

endmodule

// File: tb/tb_encoder_scan_ctrl.sv
// Directed bench for encoder_scan_ctrl: reset, direction, clamping, arbitration order, overflow, mid-scan reset, acceleration.
module tb_encoder_scan_ctrl;

  localparam int N_ENC    = 4;
  localparam int TICK_DIV = 16;
  localparam int VAL_W    = 6;
  localparam int MAX_VAL  = 36;
  localparam int INIT_VAL = 18;
  localparam int IDW      = 3;
  localparam logic [N_ENC*VAL_W-1:0] ALL_INIT = {N_ENC{6'd18}};

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_ENC-1:0]       enc_a, enc_b;
  logic [N_ENC*VAL_W-1:0] value_flat;
  logic                   evt_valid, evt_ready, evt_dir, scan_busy;
  logic [IDW-1:0]         evt_id;
  logic [VAL_W-1:0]       evt_value;
  logic [N_ENC-1:0]       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encoder_scan_ctrl #(
    .N_ENC(N_ENC), .TICK_DIV(TICK_DIV), .VAL_W(VAL_W),
    .MAX_VAL(MAX_VAL), .INIT_VAL(INIT_VAL), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .value_flat(value_flat), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_dir(evt_dir), .evt_value(evt_value),
    .overflow(overflow), .scan_busy(scan_busy)
  );

  function automatic int val_of(input int ch);
    return int'(value_flat[ch*VAL_W +: VAL_W]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    enc_a = '1; enc_b = '1; evt_ready = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic fall(input int ch, input logic b);
    enc_b[ch] = b;
    enc_a[ch] = 1'b0;
  endtask

  task automatic rise(input int ch);
    enc_a[ch] = 1'b1;
  endtask

  task automatic accept_evt();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (evt_valid === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: evt_valid stayed 0 for 300 cycles, required 1", nm);
    end
  endtask

  task automatic scan_done();
    bit seen, ok;
    seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (scan_busy === 1'b1) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL scan_done: no complete scan within 100 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cnt;
    enc_a = '1; enc_b = '1; evt_ready = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (scan_busy !== 1'b0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b valid=%b, required 0 0", scan_busy, evt_valid);
    end
    n_tests++;
    if (evt_id !== '0 || evt_dir !== 1'b0 || evt_value !== '0) begin
      n_fail++;
      $display("FAIL reset_evt: id=%0d dir=%b val=%0d, required 0 0 0", evt_id, evt_dir, evt_value);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(5);
    n_tests++;
    if (value_flat !== ALL_INIT) begin
      n_fail++;
      $display("FAIL idle_values: got %h, required %h", value_flat, ALL_INIT);
    end
    n_tests++;
    if (evt_valid !== 1'b0 || overflow !== '0) begin
      n_fail++;
      $display("FAIL idle_quiet: valid=%b ovf=%b, required 0 0000", evt_valid, overflow);
    end
    for (int i = 0; i < 100 && scan_busy !== 1'b1; i++) @(negedge clk);
    cnt = 0;
    while (scan_busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt != N_ENC) begin
      n_fail++;
      $display("FAIL scan_len: got %0d cycles, required %0d", cnt, N_ENC);
    end
  endtask

  task automatic test_direction();
    fall(1, 1'b0);
    wait_ticks(3);
    wait_valid("dir_ccw_valid");
    n_tests++;
    if (evt_id !== 3'd1 || evt_dir !== 1'b1 || evt_value !== 6'd19) begin
      n_fail++;
      $display("FAIL dir_ccw: id=%0d dir=%b val=%0d, required 1 1 19", evt_id, evt_dir, evt_value);
    end
    accept_evt();
    rise(1);
    wait_ticks(3);
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_single: evt_valid=%b after accept, required 0", evt_valid);
    end
    do_reset();
    fall(1, 1'b1);
    wait_ticks(3);
    wait_valid("dir_cw_valid");
    n_tests++;
    if (evt_id !== 3'd1 || evt_dir !== 1'b0 || evt_value !== 6'd17) begin
      n_fail++;
      $display("FAIL dir_cw: id=%0d dir=%b val=%0d, required 1 0 17", evt_id, evt_dir, evt_value);
    end
    n_tests++;
    if (val_of(1) != 17) begin
      n_fail++;
      $display("FAIL dir_cw_flat: ch1=%0d, required 17", val_of(1));
    end
    accept_evt();
    rise(1);
    enc_b[1] = 1'b1;
    wait_ticks(3);
  endtask

  task automatic test_saturate();
    int expv;
    for (int k = 1; k <= 20; k++) begin
      fall(0, 1'b0);
      wait_valid("sat_up_valid");
      expv = (INIT_VAL + k > MAX_VAL) ? MAX_VAL : INIT_VAL + k;
      n_tests++;
      if (int'(evt_value) != expv || evt_dir !== 1'b1 || evt_id !== 3'd0) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: id=%0d dir=%b val=%0d, required 0 1 %0d", k, evt_id, evt_dir, evt_value, expv);
      end
      accept_evt();
      rise(0);
      wait_ticks(3);
    end
    for (int k = 1; k <= 40; k++) begin
      fall(0, 1'b1);
      wait_valid("sat_dn_valid");
      expv = (MAX_VAL - k < 0) ? 0 : MAX_VAL - k;
      n_tests++;
      if (int'(evt_value) != expv || evt_dir !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_dn[%0d]: dir=%b val=%0d, required 0 %0d", k, evt_dir, evt_value, expv);
      end
      accept_evt();
      rise(0);
      wait_ticks(3);
    end
    n_tests++;
    if (val_of(0) != 0) begin
      n_fail++;
      $display("FAIL sat_floor: ch0=%0d, required 0", val_of(0));
    end
  endtask

  task automatic test_back_to_back();
    logic [IDW-1:0]   ids  [3];
    logic [VAL_W-1:0] vals [3];
    int got;
    bit gap_bad, prev_acc;
    do_reset();
    fall(0, 1'b0); fall(2, 1'b0); fall(3, 1'b0);
    wait_ticks(3);
    repeat (100) @(negedge clk);
    n_tests++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_hold: valid=%b id=%0d, required 1 0", evt_valid, evt_id);
    end
    for (int i = 0; i < 3; i++) begin ids[i] = '1; vals[i] = '0; end
    got = 0; gap_bad = 1'b0; prev_acc = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 80 && got < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (prev_acc && evt_valid === 1'b1) gap_bad = 1'b1;
      prev_acc = 1'b0;
      if (evt_valid === 1'b1) begin
        ids[got] = evt_id; vals[got] = evt_value; got++; prev_acc = 1'b1;
      end
    end
    @(negedge clk);
    if (prev_acc && evt_valid === 1'b1) gap_bad = 1'b1;
    evt_ready = 1'b0;
    n_tests++;
    if (got != 3 || ids[0] !== 3'd0 || ids[1] !== 3'd2 || ids[2] !== 3'd3) begin
      n_fail++;
      $display("FAIL b2b_order: n=%0d ids=%0d,%0d,%0d, required 3 ids 0,2,3", got, ids[0], ids[1], ids[2]);
    end
    n_tests++;
    if (vals[0] !== 6'd19 || vals[1] !== 6'd19 || vals[2] !== 6'd19) begin
      n_fail++;
      $display("FAIL b2b_vals: %0d,%0d,%0d, required 19,19,19", vals[0], vals[1], vals[2]);
    end
    n_tests++;
    if (gap_bad) begin
      n_fail++;
      $display("FAIL b2b_gap: evt_valid high the cycle after an accept, required low");
    end
    n_tests++;
    if (overflow !== '0) begin
      n_fail++;
      $display("FAIL b2b_ovf: overflow=%b, required 0000", overflow);
    end
    rise(0); rise(2); rise(3);
    wait_ticks(3);
  endtask

  task automatic test_overflow();
    fall(0, 1'b0);
    wait_valid("ovf_ch0_valid");
    fall(2, 1'b0);
    wait_ticks(3);
    rise(2);
    wait_ticks(3);
    fall(2, 1'b0);
    wait_ticks(3);
    n_tests++;
    if (overflow !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovf_flag: overflow=%b, required 0100", overflow);
    end
    n_tests++;
    if (val_of(2) != 21) begin
      n_fail++;
      $display("FAIL ovf_value: ch2=%0d, required 21", val_of(2));
    end
    n_tests++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd0 || evt_value !== 6'd20) begin
      n_fail++;
      $display("FAIL ovf_stable: valid=%b id=%0d val=%0d, required 1 0 20", evt_valid, evt_id, evt_value);
    end
    accept_evt();
    wait_valid("ovf_ch2_valid");
    n_tests++;
    if (evt_id !== 3'd2 || evt_dir !== 1'b1 || evt_value !== 6'd21) begin
      n_fail++;
      $display("FAIL ovf_event: id=%0d dir=%b val=%0d, required 2 1 21", evt_id, evt_dir, evt_value);
    end
    accept_evt();
    rise(0); rise(2);
    wait_ticks(3);
    n_tests++;
    if (evt_valid !== 1'b0 || overflow !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovf_single: valid=%b ovf=%b, required 0 0100", evt_valid, overflow);
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 100 && scan_busy !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (scan_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_wait: scan_busy=%b, required 1", scan_busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (scan_busy !== 1'b0 || overflow !== '0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: busy=%b ovf=%b valid=%b, required 0 0000 0", scan_busy, overflow, evt_valid);
    end
    n_tests++;
    if (value_flat !== ALL_INIT) begin
      n_fail++;
      $display("FAIL midrst_values: got %h, required %h", value_flat, ALL_INIT);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_accel();
    int e1, e2, e3;
`ifdef ENC_ACCEL_EN
    e1 = 19; e2 = 21; e3 = 22;
`else
    e1 = 19; e2 = 20; e3 = 21;
`endif
    do_reset();
    evt_ready = 1'b1;
    scan_done();
    fall(3, 1'b0);
    scan_done(); scan_done();
    n_tests++;
    if (val_of(3) != e1) begin
      n_fail++;
      $display("FAIL accel_first: ch3=%0d, required %0d", val_of(3), e1);
    end
    rise(3);
    scan_done(); scan_done();
    fall(3, 1'b0);
    scan_done(); scan_done();
    n_tests++;
    if (val_of(3) != e2) begin
      n_fail++;
      $display("FAIL accel_fast: ch3=%0d, required %0d", val_of(3), e2);
    end
    rise(3);
    for (int i = 0; i < 6; i++) scan_done();
    fall(3, 1'b0);
    scan_done(); scan_done();
    n_tests++;
    if (val_of(3) != e3) begin
      n_fail++;
      $display("FAIL accel_slow: ch3=%0d, required %0d", val_of(3), e3);
    end
    rise(3);
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direction();
    test_saturate();
    test_back_to_back();
    test_overflow();
    test_reset_mid_scan();
    test_accel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_scan_ctrl.md
Name: encoder_scan_ctrl

Overview:
- Time-multiplexed controller for N EC11-style quadrature encoders on the audio front panel.
- Sequences one shared sample/debounce/direction datapath across all encoder channels on a slow sample tick.
- Holds one clamped position value per channel and reports step events to a downstream consumer through a round-robin valid/ready port.
- Sits between the panel pins and the control-register/volume logic.

Parameters:
- N_ENC, 4, number of encoder channels (2..8).
- TICK_DIV, 100000, clk cycles per sample tick (2 ms at 50 MHz).
- VAL_W, 6, width of each position value.
- MAX_VAL, 36, upper clamp of position value.
- INIT_VAL, 18, reset value of every position.
- IDW, 3, width of the channel index; must satisfy 2^IDW >= N_ENC.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- enc_a, input, N_ENC, raw A pins, asynchronous.
- enc_b, input, N_ENC, raw B pins, asynchronous.
- value_flat, output, N_ENC*VAL_W, positions; channel i occupies bits [i*VAL_W +: VAL_W].
- evt_valid, output, 1, step event available.
- evt_ready, input, 1, consumer accepts the event.
- evt_id, output, IDW, channel of the presented event.
- evt_dir, output, 1, direction: 1 = ccw (+1), 0 = cw (-1).
- evt_value, output, VAL_W, channel position at presentation time.
- overflow, output, N_ENC, sticky per-channel flag: an event was merged before being consumed.
- scan_busy, output, 1, high while the scan FSM is in SCAN.

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. On reset:
  - all values = INIT_VAL; evt_valid = 0; evt_id = 0; evt_dir = 0; evt_value = 0; overflow = 0; scan_busy = 0.
  - debounced A/B and last-A state = 1 (idle-high pins); tick counter = 0.
- Input path: each enc_a/enc_b bit passes through a 2-flop synchronizer before use.
- Tick: counter runs 0..TICK_DIV-1 and pulses tick for one cycle at wrap.
- FSM states:
  - IDLE: wait for tick, then go to SCAN with idx = 0.
  - SCAN: process channel idx in one cycle; idx increments; after idx = N_ENC-1, return to IDLE. SCAN lasts exactly N_ENC cycles.
- Per-channel processing in SCAN:
  - Debounce: db_A updates to the synced A only if the synced A equals the raw sample stored at the previous tick; same rule for B. Prev-sample storage updates every tick.
  - Step detection: a step occurs when db_A goes 1 -> 0. Direction is db_B after update: 0 gives ccw (+1), 1 gives cw (-1).
  - Clamp: +1 saturates at MAX_VAL; -1 saturates at 0. A saturated step still raises an event with the value unchanged.
- Event flags:
  - A step sets the channel's pending flag and stores dir.
  - If pending is already set, dir is overwritten, the value still updates, and overflow[idx] is set. overflow clears only on reset.
- Arbiter:
  - When evt_valid = 0, it selects the lowest pending channel at or after rr_ptr (wrapping) and asserts evt_valid on the next cycle.
  - evt_id, evt_dir and evt_value stay stable while evt_valid = 1 && evt_ready = 0.
  - On evt_valid && evt_ready: clear that channel's pending flag and set rr_ptr = evt_id + 1 (mod N_ENC). evt_valid drops for at least one cycle.
- Simultaneous events:
  - A SCAN step on the channel currently presented (valid high) counts as a merge: overflow is set and pending stays set. The presented fields are not changed; the new event is presented afterwards.
  - If acceptance and a new step on the same channel occur in the same cycle, the step wins and pending remains set.
- Latency: a pin edge stable for two ticks becomes an event within 2 ticks + N_ENC + 4 cycles.
- Reset mid-SCAN: the FSM returns to IDLE and the whole reset state above is reloaded.

Optional Feature:
- Macro: ENC_ACCEL_EN.
- Defined: each channel keeps a tick-age counter saturating at 15. A step arriving when age < 4 moves the value by 2 instead of 1, still clamped to [0, MAX_VAL]. age resets to 0 on every step.
- Undefined: step size is always 1; no age counters are synthesized.

Decomposition:
- Package enc_pkg holds:
  - localparams DIR_CW = 0 and DIR_CCW = 1.
  - FSM state encoding: IDLE, SCAN.
  - ACCEL_THRESH = 4.
- One sub-module enc_rr_arbiter: N-way round-robin select from the pending vector and rr_ptr; purely combinational grant plus index output.
- Debounce, step detection and value storage stay in the top module as per-channel arrays indexed by idx.

Test Plan:
- Reset, then idle pins for 5 ticks -> value_flat shows 18 on every channel; evt_valid = 0; overflow = 0.
- Channel 1: A falls with B = 0, held 3 ticks -> one event with evt_id = 1, evt_dir = 1, evt_value = 19. Same edge with B = 1 -> evt_dir = 0, evt_value = 17.
- Channel 0 stepped ccw 20 times, each event accepted -> value saturates at 36; events 19 and 20 both report 36. 40 cw steps -> value saturates at 0.
- Channels 0, 2, 3 step in the same tick with evt_ready held low for 100 cycles, then high -> events presented in order 0, 2, 3, each with evt_valid low for at least one cycle between them.
- Channel 2 steps twice with evt_ready = 0 -> overflow[2] = 1, value moved by 2, single event with the latest dir. Assert rst mid-SCAN -> overflow = 0, values = 18, FSM in IDLE.
- ENC_ACCEL_EN defined: two channel-3 steps 2 ticks apart -> 18 -> 19 -> 21. Steps 6 ticks apart -> +1 each.
